// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// Optional build macro FETCH_PERF_CNT_EN (see fetch_unit.sv) adds perf counters.
package fetch_unit_pkg;

    // Width of one instruction word returned by the memory port.
    localparam int INST_WIDTH = 32;

    // Byte distance between consecutive sequential fetches.
    localparam int PC_STEP = 4;

    // Occupancy counters (queue count, in-flight, discard) can reach DEPTH itself,
    // so they carry one bit more than the queue index.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory port, redirect input and decode handshake.
// master: the fetch unit side; slave: the memory/decode/branch environment side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  imem_req;
    logic [XLEN-1:0]       imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  redirect;
    logic [XLEN-1:0]       redirect_addr;
    logic                  misalign_err;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       inst_pc;

    modport master (
        output imem_req, imem_addr, misalign_err, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, misalign_err, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue holding {inst, pc} pairs, with flush.
// Head is read combinationally so decode sees a new entry the cycle after push.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [INST_WIDTH-1:0]        push_inst_i,
    input  logic [XLEN-1:0]              push_pc_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    output logic [INST_WIDTH-1:0]        head_inst_o,
    output logic [XLEN-1:0]              head_pc_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0]       pc_mem   [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    // Flush wins over push/pop; full/empty guards keep pointers consistent.
    assign push_ok = push_i & ~flush_i & (count_q != FULL);
    assign pop_ok  = pop_i  & ~flush_i & (count_q != '0);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            inst_mem[wr_ptr_q] <= push_inst_i;
            pc_mem[wr_ptr_q]   <= push_pc_i;
        end
    end

    assign valid_o     = (count_q != '0);
    // Empty queue presents zeros so stale or unwritten entries never leak out.
    assign head_inst_o = valid_o ? inst_mem[rd_ptr_q] : '0;
    assign head_pc_o   = valid_o ? pc_mem[rd_ptr_q]   : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-based request issue,
// in-order response tracking with discard after redirect, and the decode queue.
// Optional macro FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count;
    logic            started_q;
    logic            issue, rsp, push, pop, flush, q_valid;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc    = {bus.redirect_addr[XLEN-1:2], 2'b00};
    assign flush       = bus.redirect;
    // Queue slots already promised: held entries plus every outstanding response.
    assign credit_used = {1'b0, count} + {1'b0, inflight_q};

    // started_q keeps every output quiet until the first clock after reset release.
    assign bus.imem_req     = started_q & ~bus.redirect & (credit_used < DEPTH_W);
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.misalign_err = started_q & bus.redirect & (|bus.redirect_addr[1:0]);

    assign issue = bus.imem_req & bus.imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp   = bus.imem_rvalid & (inflight_q != '0);
    assign push  = rsp & (discard_q == '0) & ~flush;
    assign pop   = q_valid & bus.inst_ready & ~flush;

    // PC, in-flight and discard bookkeeping; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(issue) - CW'(rsp);
        if (issue) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        if (flush) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            // in-flight already includes responses marked for discard by an
            // earlier redirect, so everything still outstanding after this
            // cycle is exactly what must be dropped (no issue can occur now).
            discard_d  = inflight_q - CW'(rsp);
        end else begin
            if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
            if (push) resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_VEC;
            resp_pc_q  <= RESET_VEC;
            inflight_q <= '0;
            discard_q  <= '0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            started_q  <= 1'b1;
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_inst_i (bus.imem_rdata),
        .push_pc_i   (resp_pc_q),
        .pop_i       (pop),
        .flush_i     (flush),
        .valid_o     (q_valid),
        .head_inst_o (bus.inst),
        .head_pc_o   (bus.inst_pc),
        .count_o     (count)
    );

    assign bus.inst_valid = q_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Cycles with an empty queue and number of redirects; both wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!q_valid)     stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based scoreboard and memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    fetch_unit #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .RESET_VEC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    pend_t       pend_q[$];
    item_t       exp_q[$];
    logic [31:0] pc_log[$];
    logic [31:0] model_pc;
    int          epoch = 0;
    bit          started = 1'b0;
    bit          rsp_en = 1'b1;
    int          issues = 0;
    int          mis_pulses = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (pc_log.size() > i) ? pc_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        model_pc  = 32'h0;
        started   = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    // One clock: drive memory response, check outputs mid-cycle, advance the model.
    task automatic step();
        pend_t e;
        item_t it;
        bit    exp_req, issue, rsp, pop;
        if (rsp_en && pend_q.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_q[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #2;
        exp_req = started && !bus.redirect && (exp_q.size() + pend_q.size() < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, model_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("inst", bus.inst, exp_q[0].inst);
            chk("inst_pc", bus.inst_pc, exp_q[0].pc);
        end
        chk("misalign_err", 32'(bus.misalign_err),
            32'(started && bus.redirect && bus.redirect_addr[1:0] != 2'b00));
        if (bus.misalign_err) mis_pulses++;
        issue = exp_req && bus.imem_gnt;
        rsp   = bus.imem_rvalid;
        pop   = (exp_q.size() != 0) && bus.inst_ready && !bus.redirect;
        if (exp_q.size() == 0) exp_stall++;
        if (bus.redirect) exp_flush++;
        @(posedge clk);
        if (pop) begin
            it = exp_q.pop_front();
            pc_log.push_back(it.pc);
            $display("pop  pc=%h inst=%h", it.pc, it.inst);
        end
        if (rsp) e = pend_q.pop_front();
        if (bus.redirect) begin
            exp_q.delete();
            epoch++;
            model_pc = {bus.redirect_addr[31:2], 2'b00};
        end else if (rsp && e.epoch == epoch) begin
            exp_q.push_back('{inst: mem_word(e.addr), pc: e.addr});
        end
        if (issue) begin
            pend_q.push_back('{addr: model_pc, epoch: epoch});
            model_pc = model_pc + 32'd4;
            issues++;
        end
        started = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h3;
        bus.inst_ready    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state, including a misaligned redirect that must stay silent.
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_pc", bus.inst_pc, 32'h0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'h0);
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        rst = 1'b1;

        // 1: streaming fetch from the reset vector.
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; rsp_en = 1'b1;
        repeat (10) step();
        chk("t1_pc0", log_at(0), 32'h0);
        chk("t1_pc1", log_at(1), 32'h4);
        chk("t1_pc2", log_at(2), 32'h8);

        // Asynchronous reset mid-cycle with traffic in flight.
        #2; rst = 1'b0; #1;
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_valid", 32'(bus.inst_valid), 32'h0);
        chk("arst_req", 32'(bus.imem_req), 32'h0);
        model_reset();
        bus.imem_gnt = 1'b0; bus.inst_ready = 1'b0; bus.imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 2: decode stalled -> credit limit, then one pop frees one issue.
        bus.imem_gnt = 1'b1; issues = 0;
        repeat (10) step();
        chk("t2_issues", 32'(issues), 32'd4);
        chk("t2_req_off", 32'(bus.imem_req), 32'h0);
        bus.inst_ready = 1'b1; step();
        bus.inst_ready = 1'b0; repeat (4) step();
        chk("t2_issues_after_pop", 32'(issues), 32'd5);
        bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1; repeat (6) step();

        // 3: two in flight, redirect to 0x100.
        bus.imem_gnt = 1'b1; rsp_en = 1'b0; repeat (2) step();
        bus.imem_gnt = 1'b0; rsp_en = 1'b1;
        bus.redirect = 1'b1; bus.redirect_addr = 32'h100; step();
        bus.redirect = 1'b0; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.inst_valid; i++) step();
        chk("t3_valid", 32'(bus.inst_valid), 32'h1);
        chk("t3_pc", bus.inst_pc, 32'h100);
        chk("t3_inst", bus.inst, mem_word(32'h100));
        bus.imem_gnt = 1'b0; bus.inst_ready = 1'b1; repeat (6) step();

        // 4: redirect coinciding with pop and a response.
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b0; repeat (3) step();
        chk("t4_pre_valid", 32'(bus.inst_valid), 32'h1);
        bus.inst_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_addr = 32'h300; step();
        bus.redirect = 1'b0; bus.imem_gnt = 1'b0;
        chk("t4_valid_after", 32'(bus.inst_valid), 32'h0);
        chk("t4_addr_after", bus.imem_addr, 32'h300);
        repeat (4) step();

        // 5: misaligned redirect.
        bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1; mis_pulses = 0; pc_log.delete();
        bus.redirect = 1'b1; bus.redirect_addr = 32'h102; step();
        bus.redirect = 1'b0; repeat (5) step();
        chk("t5_pulses", 32'(mis_pulses), 32'd1);
        chk("t5_first_pc", log_at(0), 32'h100);

        // PC wrap at the top of the address space.
        pc_log.delete();
        bus.redirect = 1'b1; bus.redirect_addr = 32'hFFFF_FFF8; step();
        bus.redirect = 1'b0; repeat (8) step();
        chk("wrap_pc0", log_at(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", log_at(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", log_at(2), 32'h0000_0000);

        // Back-to-back redirects with responses still outstanding.
        bus.imem_gnt = 1'b0; repeat (4) step();
        bus.imem_gnt = 1'b1; rsp_en = 1'b0; repeat (2) step();
        pc_log.delete();
        bus.redirect = 1'b1; bus.redirect_addr = 32'h400; step();
        rsp_en = 1'b1; bus.redirect_addr = 32'h500; step();
        bus.redirect = 1'b0; repeat (8) step();
        chk("b2b_first_pc", log_at(0), 32'h500);
        chk("b2b_second_pc", log_at(1), 32'h504);

`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", stall_cnt, 32'(exp_stall));
        chk("perf_flush", flush_cnt, 32'(exp_flush));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
